wb_arbiter: RTL and testbench

- Collects completed results from the execution units and writes up to WB_WIDTH of them per cycle into the physical register file write ports (wb_phyf_id / wb_phyf_data / wb_phyf_we).
- Sits directly upstream of the physical register file, between the execute units and the regfile writeback ports.
- Each execution unit has a small result FIFO. A round-robin grant picks which FIFO heads drain each cycle.

---
 rtl/wb_arbiter_pkg.sv | 29 ++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types and default sizing for the writeback arbiter
//
// Purpose: holds the FIFO entry type and the default dimensions used by
// wb_arbiter and wb_fifo. The entry widths here are the ones the FIFO storage
// is built from; wb_arbiter refuses to elaborate with different widths.
// Ports: none (package).

package wb_arbiter_pkg;

  localparam int EU_NUM           = 4;
  localparam int WB_WIDTH         = 2;
  localparam int FIFO_DEPTH       = 4;
  localparam int FIFO_PTR_W       = $clog2(FIFO_DEPTH);
  localparam int PHY_REG_ID_WIDTH = 6;
  localparam int REG_DATA_WIDTH   = 32;

  typedef struct packed {
    logic [PHY_REG_ID_WIDTH-1:0] id;
    logic [REG_DATA_WIDTH-1:0]   data;
  } wb_entry_t;

  // A result only needs a regfile write when it targets a real register;
  // physical register 0 is never written.
  function automatic logic needs_writeback(input logic rd_enable,
                                           input logic [PHY_REG_ID_WIDTH-1:0] id);
    return rd_enable && (id != '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-execution-unit circular result FIFO
//
// Purpose: buffers completed results of one execution unit until the
// writeback arbiter grants its head.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        enqueue push_entry (ignored when full)
//   push_entry  entry to enqueue
//   pop         dequeue the head (ignored when empty)
//   flush       discard all entries at the edge
//   full, empty occupancy flags, registered state only
//   head        entry at the read pointer (valid when !empty)

module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  input  logic      flush,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush && !rst;
  assign do_pop  = pop && !empty && !flush && !rst;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter in front of the physical regfile
//
// Purpose: each execution unit feeds a small result FIFO; every cycle a
// round-robin scan starting at rr_ptr grants up to WB_WIDTH non-empty FIFO
// heads, lane 0 first. Granted heads are dequeued at the edge and written
// through a registered lane stage onto the regfile write ports.
// Optional: define WB_ARBITER_BYPASS_EN to let an input arriving at an empty
// FIFO compete in the same cycle's scan and skip the FIFO when granted.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   eu_valid/ready    per-EU result handshake
//   eu_rd_enable      result writes a register
//   eu_phy_id/data    per-EU destination register and value
//   flush             drop all queued and incoming results
//   wb_phyf_id/data/we  per-lane regfile write port

module wb_arbiter #(
  parameter int EU_NUM           = wb_arbiter_pkg::EU_NUM,
  parameter int WB_WIDTH         = wb_arbiter_pkg::WB_WIDTH,
  parameter int FIFO_DEPTH       = wb_arbiter_pkg::FIFO_DEPTH,
  parameter int PHY_REG_ID_WIDTH = wb_arbiter_pkg::PHY_REG_ID_WIDTH,
  parameter int REG_DATA_WIDTH   = wb_arbiter_pkg::REG_DATA_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [EU_NUM-1:0]                          eu_valid,
  output logic [EU_NUM-1:0]                          eu_ready,
  input  logic [EU_NUM-1:0]                          eu_rd_enable,
  input  logic [EU_NUM-1:0][PHY_REG_ID_WIDTH-1:0]    eu_phy_id,
  input  logic [EU_NUM-1:0][REG_DATA_WIDTH-1:0]      eu_data,
  input  logic                                       flush,
  output logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]  wb_phyf_id,
  output logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]    wb_phyf_data,
  output logic [WB_WIDTH-1:0]                        wb_phyf_we
);

  import wb_arbiter_pkg::*;

  localparam int EU_IDX_W = (EU_NUM > 1) ? $clog2(EU_NUM) : 1;
  localparam int LANE_W   = (WB_WIDTH > 1) ? $clog2(WB_WIDTH) : 1;

  // FIFO storage is built from wb_entry_t, so the entry widths are fixed by
  // the package; the depth must be a power of two for pointer wrap.
  if (PHY_REG_ID_WIDTH != wb_arbiter_pkg::PHY_REG_ID_WIDTH ||
      REG_DATA_WIDTH != wb_arbiter_pkg::REG_DATA_WIDTH ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_guard
    $error("wb_arbiter: unsupported parameter combination");
  end

  logic [EU_NUM-1:0]   fifo_full;
  logic [EU_NUM-1:0]   fifo_empty;
  logic [EU_NUM-1:0]   push_ok;
  logic [EU_NUM-1:0]   fifo_push;
  logic [EU_NUM-1:0]   fifo_pop;
  logic [EU_NUM-1:0]   head_vld;
  logic [EU_NUM-1:0]   grant;
  wb_entry_t           in_entry   [EU_NUM];
  wb_entry_t           fifo_head  [EU_NUM];
  wb_entry_t           head_entry [EU_NUM];
  logic [LANE_W-1:0]   lane_of    [EU_NUM];

  logic [EU_IDX_W-1:0] rr_ptr;
  logic [EU_IDX_W-1:0] rr_next;
  logic [EU_IDX_W-1:0] last_idx;
  logic                any_grant;

  wb_entry_t           lane_entry [WB_WIDTH];
  logic [WB_WIDTH-1:0] lane_vld;

  // Ready depends only on FIFO occupancy plus flush/rst, never on eu_valid,
  // so a full FIFO cannot accept even if it is being drained this cycle.
  assign eu_ready = ~fifo_full & {EU_NUM{!flush && !rst}};

  for (genvar e = 0; e < EU_NUM; e++) begin : g_eu
    assign in_entry[e] = '{id: eu_phy_id[e], data: eu_data[e]};
    // Transfers that write nothing are accepted and dropped here.
    assign push_ok[e]  = eu_valid[e] && eu_ready[e] &&
                         needs_writeback(eu_rd_enable[e], eu_phy_id[e]);

`ifdef WB_ARBITER_BYPASS_EN
    // An empty FIFO lets the incoming result compete directly; if it wins
    // it never enters the FIFO, so per-EU ordering is kept.
    assign head_vld[e]   = !fifo_empty[e] || push_ok[e];
    assign head_entry[e] = fifo_empty[e] ? in_entry[e] : fifo_head[e];
    assign fifo_push[e]  = push_ok[e] && !(fifo_empty[e] && grant[e]);
`else
    assign head_vld[e]   = !fifo_empty[e];
    assign head_entry[e] = fifo_head[e];
    assign fifo_push[e]  = push_ok[e];
`endif

    assign fifo_pop[e] = grant[e] && !fifo_empty[e];

    wb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fifo_push[e]),
      .push_entry (in_entry[e]),
      .pop        (fifo_pop[e]),
      .flush      (flush),
      .full       (fifo_full[e]),
      .empty      (fifo_empty[e]),
      .head       (fifo_head[e])
    );
  end

  // Round-robin scan: visit rr_ptr, rr_ptr+1, ... and hand out lanes in
  // visiting order until WB_WIDTH grants have been made.
  always_comb begin
    logic [EU_IDX_W:0]   sum;
    logic [EU_IDX_W-1:0] idx;
    logic [LANE_W:0]     n_grant;
    grant     = '0;
    last_idx  = rr_ptr;
    any_grant = 1'b0;
    n_grant   = '0;
    sum       = '0;
    idx       = '0;
    for (int e = 0; e < EU_NUM; e++) begin
      lane_of[e] = '0;
    end
    for (int k = 0; k < EU_NUM; k++) begin
      sum = {1'b0, rr_ptr} + (EU_IDX_W+1)'(k);
      if (sum >= (EU_IDX_W+1)'(EU_NUM)) begin
        sum = sum - (EU_IDX_W+1)'(EU_NUM);
      end
      idx = sum[EU_IDX_W-1:0];
      if (head_vld[idx] && (n_grant < (LANE_W+1)'(WB_WIDTH)) && !flush && !rst) begin
        grant[idx]   = 1'b1;
        lane_of[idx] = n_grant[LANE_W-1:0];
        last_idx     = idx;
        any_grant    = 1'b1;
        n_grant      = n_grant + (LANE_W+1)'(1);
      end
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (any_grant) begin
      rr_next = (last_idx == EU_IDX_W'(EU_NUM - 1)) ? '0 : last_idx + EU_IDX_W'(1);
    end
  end

  // Lane mux: ungranted lanes carry an all-zero entry.
  always_comb begin
    for (int l = 0; l < WB_WIDTH; l++) begin
      lane_vld[l]   = 1'b0;
      lane_entry[l] = '0;
      for (int e = 0; e < EU_NUM; e++) begin
        if (grant[e] && (lane_of[e] == LANE_W'(l))) begin
          lane_vld[l]   = 1'b1;
          lane_entry[l] = head_entry[e];
        end
      end
    end
  end

  // Flush needs no branch here: it suppresses all grants, so the lanes load
  // zeros and rr_ptr holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      wb_phyf_we   <= '0;
      wb_phyf_id   <= '0;
      wb_phyf_data <= '0;
    end else begin
      rr_ptr     <= rr_next;
      wb_phyf_we <= lane_vld;
      for (int l = 0; l < WB_WIDTH; l++) begin
        wb_phyf_id[l]   <= lane_entry[l].id;
        wb_phyf_data[l] <= lane_entry[l].data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter

module tb_wb_arbiter;

`ifdef WB_ARBITER_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [3:0]       eu_valid;
  logic [3:0]       eu_ready;
  logic [3:0]       eu_rd_enable;
  logic [3:0][5:0]  eu_phy_id;
  logic [3:0][31:0] eu_data;
  logic [1:0][5:0]  wb_phyf_id;
  logic [1:0][31:0] wb_phyf_data;
  logic [1:0]       wb_phyf_we;

  int total = 0;
  int bad   = 0;
  int written;
  int sent [4];
  logic [39:0] exp_q [$];

  wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .eu_valid     (eu_valid),
    .eu_ready     (eu_ready),
    .eu_rd_enable (eu_rd_enable),
    .eu_phy_id    (eu_phy_id),
    .eu_data      (eu_data),
    .flush        (flush),
    .wb_phyf_id   (wb_phyf_id),
    .wb_phyf_data (wb_phyf_data),
    .wb_phyf_we   (wb_phyf_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    eu_valid     = '0;
    eu_rd_enable = '0;
    eu_phy_id    = '0;
    eu_data      = '0;
    flush        = 1'b0;
  endtask

  task automatic send(input int e, input logic [5:0] id, input logic [31:0] data, input logic rd_en);
    eu_valid[e]     = 1'b1;
    eu_rd_enable[e] = rd_en;
    eu_phy_id[e]    = id;
    eu_data[e]      = data;
  endtask

  task automatic check_lane(input string tag, input int l, input logic we,
                            input logic [5:0] id, input logic [31:0] data);
    check({tag, "_we"}, 64'(wb_phyf_we[l]), 64'(we));
    check({tag, "_id"}, 64'(wb_phyf_id[l]), 64'(id));
    check({tag, "_data"}, 64'(wb_phyf_data[l]), 64'(data));
  endtask

  // Leaves the bench just after the negedge of the first cycle out of reset.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    check({tag, "_rst_ready"}, 64'(eu_ready), 64'h0);
    @(negedge clk);
    check_lane({tag, "_rst_l0"}, 0, 1'b0, 6'd0, 32'd0);
    check_lane({tag, "_rst_l1"}, 1, 1'b0, 6'd0, 32'd0);
    rst = 1'b0;
    #1;
    check({tag, "_post_rst_ready"}, 64'(eu_ready), 64'hf);
  endtask

  // Stream scoreboard: per-EU order is checked by matching the oldest
  // outstanding entry of the EU encoded in id[5:4].
  task automatic monitor(input string tag);
    int  idx;
    logic found;
    check({tag, "_lane_order"}, 64'(wb_phyf_we[1] && !wb_phyf_we[0]), 64'h0);
    for (int l = 0; l < 2; l++) begin
      if (wb_phyf_we[l]) begin
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!found && exp_q[i][39:38] == wb_phyf_id[l][5:4]) begin
            found = 1'b1;
            idx   = i;
          end
        end
        check({tag, "_known"}, 64'(found), 64'h1);
        if (found) begin
          check({tag, "_entry"}, 64'({wb_phyf_id[l], wb_phyf_data[l]}), 64'(exp_q[idx][37:0]));
          exp_q.delete(idx);
        end
        written++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // 1: single result from EU0, fixed latency, then idle
    do_reset("t1");
    @(negedge clk);
    send(0, 6'd5, 32'h1234, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == LAT) begin
        check_lane("t1_hit_l0", 0, 1'b1, 6'd5, 32'h1234);
      end else begin
        check_lane("t1_idle_l0", 0, 1'b0, 6'd0, 32'd0);
      end
      check_lane("t1_l1", 1, 1'b0, 6'd0, 32'd0);
    end

    // 2: all four EUs at once, two lanes per cycle in rr order
    do_reset("t2");
    @(negedge clk);
    for (int e = 0; e < 4; e++) send(e, 6'(8'h11 + e), 32'(32'ha000 + e), 1'b1);
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == LAT) begin
        check_lane("t2_c0_l0", 0, 1'b1, 6'h11, 32'ha000);
        check_lane("t2_c0_l1", 1, 1'b1, 6'h12, 32'ha001);
      end else if (i == LAT + 1) begin
        check_lane("t2_c1_l0", 0, 1'b1, 6'h13, 32'ha002);
        check_lane("t2_c1_l1", 1, 1'b1, 6'h14, 32'ha003);
      end else begin
        check("t2_idle_we", 64'(wb_phyf_we), 64'h0);
      end
    end
    // rr_ptr back at 0: EU0 must win lane 0 over EU3
    @(negedge clk);
    send(0, 6'h21, 32'hb000, 1'b1);
    send(3, 6'h24, 32'hb003, 1'b1);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      idle_inputs();
    end
    check_lane("t2_rr_l0", 0, 1'b1, 6'h21, 32'hb000);
    check_lane("t2_rr_l1", 1, 1'b1, 6'h24, 32'hb003);

    // 3: every EU streams 8 results; FIFOs fill, nothing lost, order kept
    do_reset("t3");
    written = 0;
    exp_q.delete();
    for (int e = 0; e < 4; e++) sent[e] = 0;
    for (int cyc = 1; cyc <= 80 && written < 32; cyc++) begin
      @(negedge clk);
      monitor("t3");
      for (int e = 0; e < 4; e++) begin
        if (sent[e] < 8) begin
          send(e, 6'(e * 16 + sent[e] + 1), 32'(e * 65536 + sent[e]), 1'b1);
        end else begin
          eu_valid[e] = 1'b0;
        end
      end
      #1;
`ifndef WB_ARBITER_BYPASS_EN
      if (cyc == 7) begin
        check("t3_ready_c7", 64'(eu_ready), 64'h3);
        check("t3_eu2_accepts", 64'(sent[2]), 64'd6);
      end
      if (cyc == 8) check("t3_ready_c8", 64'(eu_ready), 64'hc);
`endif
      for (int e = 0; e < 4; e++) begin
        if (eu_valid[e] && eu_ready[e]) begin
          exp_q.push_back({2'(e), eu_phy_id[e], eu_data[e]});
          sent[e]++;
        end
      end
    end
    idle_inputs();
    check("t3_written", 64'(written), 64'd32);
    check("t3_leftover", 64'(exp_q.size()), 64'd0);

    // 4: three queued entries dropped by a one-cycle flush
    do_reset("t4");
    @(negedge clk);
    for (int e = 0; e < 3; e++) send(e, 6'(8'h31 + e), 32'(32'hc000 + e), 1'b1);
    @(negedge clk);
    idle_inputs();
`ifndef WB_ARBITER_BYPASS_EN
    check("t4_pre_flush_we", 64'(wb_phyf_we), 64'h0);
`endif
    flush = 1'b1;
    send(3, 6'h3f, 32'hdead, 1'b1);
    #1;
    check("t4_flush_ready", 64'(eu_ready), 64'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t4_after_ready", 64'(eu_ready), 64'hf);
    for (int i = 0; i < 5; i++) begin
      check("t4_after_we", 64'(wb_phyf_we), 64'h0);
      @(negedge clk);
    end

    // 5: non-writing results are accepted but never written
    do_reset("t5");
    @(negedge clk);
    send(1, 6'd7, 32'h77, 1'b0);
    #1;
    check("t5_ready_rden0", 64'(eu_ready), 64'hf);
    @(negedge clk);
    send(1, 6'd0, 32'h88, 1'b1);
    #1;
    check("t5_ready_id0", 64'(eu_ready), 64'hf);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      check("t5_we", 64'(wb_phyf_we), 64'h0);
    end

`ifdef WB_ARBITER_BYPASS_EN
    // 6: bypass into an empty FIFO lands one cycle later
    do_reset("t6");
    @(negedge clk);
    send(3, 6'd9, 32'h99, 1'b1);
    @(negedge clk);
    idle_inputs();
    check_lane("t6_l0", 0, 1'b1, 6'd9, 32'h99);
    check_lane("t6_l1", 1, 1'b0, 6'd0, 32'd0);
`endif

    // 7: reset mid-stream discards everything queued
    do_reset("t7");
    @(negedge clk);
    for (int e = 0; e < 4; e++) send(e, 6'(8'h01 + e), 32'(32'he000 + e), 1'b1);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t7_we", 64'(wb_phyf_we), 64'h0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
